cache_perf_monitor: RTL and testbench



---
 rtl/cache_perf_pkg.sv | 19 +
 rtl/cache_perf_chan.sv | 105 ++++++++++
 rtl/cache_perf_monitor.sv | 74 +++++++
 tb/tb_cache_perf_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_perf_pkg.sv
// rtl/cache_perf_pkg.sv - shared types and register indices for the cache performance monitor.
package cache_perf_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_e;

  typedef enum logic [1:0] {
    ACC    = 2'd0,
    MISS   = 2'd1,
    STALL  = 2'd2,
    MAXLAT = 2'd3
  } perf_reg_e;

  localparam int REG_IDX_W = 2;
  localparam int NUM_REGS  = 4;

endpackage

// File: rtl/cache_perf_chan.sv
// rtl/cache_perf_chan.sv - one monitored channel: FSM, latency counter, counters, overflow flag.
// CACHE_PERF_SATURATE_EN selects saturating counters instead of wrapping ones.
module cache_perf_chan
  import cache_perf_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int LAT_W   = 16,
  parameter int HIT_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             access,
  input  logic             resp,
  output logic [CNT_W-1:0] acc,
  output logic [CNT_W-1:0] miss,
  output logic [CNT_W-1:0] stall,
  output logic [LAT_W-1:0] maxlat,
  output logic             ovf
);

  localparam int SUM_W = ((CNT_W > LAT_W) ? CNT_W : LAT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [LAT_W-1:0] LAT_MAX   = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0] HIT_LAT_V = LAT_W'(HIT_LAT);

  chan_state_e      state_q, state_d;
  logic [LAT_W-1:0] lat_q;
  logic             complete;
  logic [LAT_W-1:0] comp_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access && !resp) state_d = WAIT;
      WAIT:    if (resp || !access) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    complete = 1'b0;
    comp_lat = '0;
    case (state_q)
      IDLE: complete = access && resp;
      WAIT: begin
        complete = resp;
        comp_lat = lat_q;
      end
      default: complete = 1'b0;
    endcase
  end

  // lat_q preloads to 1 while idle so entering WAIT already counts the first wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 lat_q <= '0;
    else if (state_q == IDLE)   lat_q <= LAT_W'(1);
    else if (lat_q != LAT_MAX)  lat_q <= lat_q + 1'b1;
  end

  logic             is_miss;
  logic [SUM_W-1:0] stall_sum;
  logic             acc_ovf, miss_ovf, stall_ovf;

  assign is_miss   = comp_lat > HIT_LAT_V;
  assign stall_sum = SUM_W'(stall) + SUM_W'(comp_lat);
  assign acc_ovf   = (acc == CNT_MAX);
  assign miss_ovf  = is_miss && (miss == CNT_MAX);
  assign stall_ovf = stall_sum > SUM_W'(CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      miss   <= '0;
      stall  <= '0;
      maxlat <= '0;
      ovf    <= 1'b0;
    end else if (clr) begin
      acc    <= '0;
      miss   <= '0;
      stall  <= '0;
      maxlat <= '0;
      ovf    <= 1'b0;
    end else if (complete && en) begin
`ifdef CACHE_PERF_SATURATE_EN
      acc   <= acc_ovf ? CNT_MAX : acc + 1'b1;
      if (is_miss) miss <= miss_ovf ? CNT_MAX : miss + 1'b1;
      stall <= stall_ovf ? CNT_MAX : stall_sum[CNT_W-1:0];
`else
      acc   <= acc + 1'b1;
      if (is_miss) miss <= miss + 1'b1;
      stall <= stall_sum[CNT_W-1:0];
`endif
      if (comp_lat > maxlat) maxlat <= comp_lat;
      ovf <= ovf | acc_ovf | miss_ovf | stall_ovf;
    end
  end

endmodule

// File: rtl/cache_perf_monitor.sv
// rtl/cache_perf_monitor.sv - per-channel cache performance counters with a registered read port.
// CACHE_PERF_SATURATE_EN (in cache_perf_chan) selects saturating counters.
module cache_perf_monitor
  import cache_perf_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 32,
  parameter int LAT_W   = 16,
  parameter int HIT_LAT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  input  logic [NUM_CH-1:0]            access,
  input  logic [NUM_CH-1:0]            resp,
  input  logic [$clog2(NUM_CH)+1:0]    rd_sel,
  output logic [CNT_W-1:0]             rd_data,
  output logic [NUM_CH-1:0]            ovf
);

  logic [CNT_W-1:0] acc_a    [NUM_CH];
  logic [CNT_W-1:0] miss_a   [NUM_CH];
  logic [CNT_W-1:0] stall_a  [NUM_CH];
  logic [LAT_W-1:0] maxlat_a [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    cache_perf_chan #(
      .CNT_W   (CNT_W),
      .LAT_W   (LAT_W),
      .HIT_LAT (HIT_LAT)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .clr    (clr),
      .access (access[g]),
      .resp   (resp[g]),
      .acc    (acc_a[g]),
      .miss   (miss_a[g]),
      .stall  (stall_a[g]),
      .maxlat (maxlat_a[g]),
      .ovf    (ovf[g])
    );
  end

  int               rd_ch;
  perf_reg_e        rd_reg;
  logic [CNT_W-1:0] rd_mux;

  // Channel indices at or beyond NUM_CH match no instance and read as zero.
  always_comb begin
    rd_ch  = int'(rd_sel >> REG_IDX_W);
    rd_reg = perf_reg_e'(rd_sel[REG_IDX_W-1:0]);
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == i) begin
        case (rd_reg)
          ACC:     rd_mux = acc_a[i];
          MISS:    rd_mux = miss_a[i];
          STALL:   rd_mux = stall_a[i];
          MAXLAT:  rd_mux = CNT_W'(maxlat_a[i]);
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_cache_perf_monitor.sv
// tb/tb_cache_perf_monitor.sv - directed table-driven bench for cache_perf_monitor.
module tb_cache_perf_monitor;

  logic        clk = 1'b0;
  logic        rst_n, en, clr;
  logic [2:0]  access, resp;
  logic [3:0]  rd_sel;
  logic [31:0] rd_data;
  logic [2:0]  ovf;

  logic        s_clr, s_access, s_resp;
  logic [1:0]  s_rd_sel;
  logic [3:0]  s_rd_data;
  logic [0:0]  s_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_perf_monitor #(.NUM_CH(3), .CNT_W(32), .LAT_W(16), .HIT_LAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .access(access), .resp(resp),
    .rd_sel(rd_sel), .rd_data(rd_data), .ovf(ovf)
  );

  cache_perf_monitor #(.NUM_CH(1), .CNT_W(4), .LAT_W(16), .HIT_LAT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(s_clr), .access(s_access), .resp(s_resp),
    .rd_sel(s_rd_sel), .rd_data(s_rd_data), .ovf(s_ovf)
  );

  typedef struct {
    int ch; int nwait; bit do_resp; bit en_v;
    int acc; int miss; int stall; int maxlat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reg(input string name, input int ch, input int r, input int exp);
    @(negedge clk);
    rd_sel = 4'(ch * 4 + r);
    @(posedge clk);
    #1;
    check(name, rd_data, 32'(exp));
  endtask

  task automatic txn(input int ch, input int nwait, input bit do_resp, input bit en_v);
    @(negedge clk);
    en = en_v;
    for (int i = 0; i < nwait; i++) begin
      access[ch] = 1'b1;
      resp[ch]   = 1'b0;
      @(negedge clk);
    end
    access[ch] = do_resp;
    resp[ch]   = do_resp;
    @(negedge clk);
    access[ch] = 1'b0;
    resp[ch]   = 1'b0;
    en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 1'b1, 1'b1, 1, 0, 0, 0};
    vecs[1] = '{1, 5, 1'b1, 1'b1, 1, 1, 5, 5};
    vecs[2] = '{1, 2, 1'b1, 1'b1, 2, 2, 7, 5};
    vecs[3] = '{2, 3, 1'b0, 1'b1, 0, 0, 0, 0};
    vecs[4] = '{2, 4, 1'b1, 1'b0, 0, 0, 0, 0};
    vecs[5] = '{2, 1, 1'b1, 1'b1, 1, 1, 1, 1};
    vecs[6] = '{0, 0, 1'b1, 1'b1, 2, 0, 0, 0};
    vecs[7] = '{0, 7, 1'b1, 1'b1, 3, 1, 7, 7};

    rst_n = 1'b0; en = 1'b1; clr = 1'b0; access = '0; resp = '0; rd_sel = '0;
    s_clr = 1'b0; s_access = 1'b0; s_resp = 1'b0; s_rd_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd_data", rd_data, 0);
    check("reset_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        check_reg($sformatf("reset_ch%0d_r%0d", c, r), c, r, 0);

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].ch, vecs[i].nwait, vecs[i].do_resp, vecs[i].en_v);
      check_reg($sformatf("v%0d_acc", i),    vecs[i].ch, 0, vecs[i].acc);
      check_reg($sformatf("v%0d_miss", i),   vecs[i].ch, 1, vecs[i].miss);
      check_reg($sformatf("v%0d_stall", i),  vecs[i].ch, 2, vecs[i].stall);
      check_reg($sformatf("v%0d_maxlat", i), vecs[i].ch, 3, vecs[i].maxlat);
    end
    check("ovf_main_clean", 32'(ovf), 0);

    // Read latency: rd_data must not follow rd_sel before the edge.
    @(negedge clk);
    rd_sel = 4'(1 * 4 + 0);
    #2;
    check("rd_not_comb", rd_data, 7);
    @(posedge clk);
    #1;
    check("rd_one_cycle", rd_data, 2);
    check_reg("rd_out_of_range", 3, 1, 0);

    // A read on the update edge returns the pre-update value.
    @(negedge clk);
    rd_sel = 4'(0);
    access[0] = 1'b1; resp[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rd_pre_update", rd_data, 3);
    @(negedge clk);
    access[0] = 1'b0; resp[0] = 1'b0;
    @(posedge clk);
    #1;
    check("rd_post_update", rd_data, 4);

    // clr on the completion cycle wins.
    @(negedge clk);
    access[0] = 1'b1; resp[0] = 1'b1; clr = 1'b1;
    @(negedge clk);
    access[0] = 1'b0; resp[0] = 1'b0; clr = 1'b0;
    check_reg("clr_ch0_acc", 0, 0, 0);
    check_reg("clr_ch0_maxlat", 0, 3, 0);
    check_reg("clr_ch1_stall", 1, 2, 0);
    check_reg("clr_ch2_acc", 2, 0, 0);

    // Transaction in flight across clr keeps its full latency.
    @(negedge clk);
    access[1] = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    resp[1] = 1'b1;
    @(negedge clk);
    access[1] = 1'b0; resp[1] = 1'b0;
    check_reg("inflight_acc", 1, 0, 1);
    check_reg("inflight_miss", 1, 1, 1);
    check_reg("inflight_stall", 1, 2, 3);
    check_reg("inflight_maxlat", 1, 3, 3);

    // Asynchronous reset while ch1 is in WAIT.
    @(negedge clk);
    access[1] = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_rd_data", rd_data, 0);
    check("rst_async_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    resp[1] = 1'b1;
    @(negedge clk);
    access[1] = 1'b0; resp[1] = 1'b0;
    check_reg("rst_fsm_acc", 1, 0, 1);
    check_reg("rst_fsm_stall", 1, 2, 1);
    check_reg("rst_fsm_maxlat", 1, 3, 1);

    // Overflow on the narrow instance: 15 hits fill ACC, the 16th overflows.
    @(negedge clk);
    s_rd_sel = 2'd0;
    s_access = 1'b1; s_resp = 1'b1;
    repeat (15) @(negedge clk);
    s_access = 1'b0; s_resp = 1'b0;
    @(posedge clk);
    #1;
    check("ovf_acc_at_max", 32'(s_rd_data), 15);
    check("ovf_not_yet", 32'(s_ovf), 0);
    @(negedge clk);
    s_access = 1'b1; s_resp = 1'b1;
    @(negedge clk);
    s_access = 1'b0; s_resp = 1'b0;
    @(posedge clk);
    #1;
`ifdef CACHE_PERF_SATURATE_EN
    check("ovf_acc_after", 32'(s_rd_data), 15);
`else
    check("ovf_acc_after", 32'(s_rd_data), 0);
`endif
    check("ovf_set", 32'(s_ovf), 1);
    @(negedge clk);
    s_rd_sel = 2'd2;
    @(posedge clk);
    #1;
    check("ovf_stall_zero", 32'(s_rd_data), 0);
    @(negedge clk);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    s_rd_sel = 2'd0;
    #1;
    check("ovf_cleared", 32'(s_ovf), 0);
    @(posedge clk);
    #1;
    check("ovf_acc_cleared", 32'(s_rd_data), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
